// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package rv_fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   // Masking keeps every bit of the operand in use while clearing the byte offset.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer holding fetched words with their PCs
// Head is read combinationally; flush drops every entry in one cycle.
module fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output fetch_entry_t rdata,
   output logic         empty,
   output logic         full,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees the slot, so a push into a full buffer is legal in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC ownership, credit-limited imem requests, redirect flush
// Wrong-path words already in flight are counted in discard and dropped on return.
module fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   redirect_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] discard;
   logic [CW-1:0] count;
   logic [CW:0]   inflight;
   logic          credit_ok;
   logic          req_fire;
   logic          rsp_take;
   logic          fifo_push;
   logic          fifo_pop;
   logic          empty;
   logic          full;
   fetch_entry_t  wr_entry;
   fetch_entry_t  head;

   assign redirect_pc = word_align(branch_target);
   assign inflight    = {1'b0, outstanding} + {1'b0, count};
   assign credit_ok   = !full && (inflight < (CW+1)'(DEPTH));

   // Gating with rst_n keeps the request quiet while reset is held.
   assign imem_req_valid = rst_n && credit_ok && !branch_taken;
   assign imem_addr      = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_take       = imem_rsp_valid && (outstanding != '0);

   assign fifo_push = imem_rsp_valid && (discard == '0) && !branch_taken;
   assign fifo_pop  = if_valid && if_ready && !branch_taken;
   assign wr_entry  = '{pc: rsp_pc, instr: imem_rsp_data};

   assign if_valid = !empty;
   assign if_pc    = empty ? 32'h0 : head.pc;
   assign if_instr = empty ? 32'h0 : head.instr;

   always_comb begin
      outstanding_nxt = outstanding;
      if (req_fire) outstanding_nxt = outstanding_nxt + 1'b1;
      if (rsp_take) outstanding_nxt = outstanding_nxt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (branch_taken) begin
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            // Everything still owed by memory is wrong-path, minus the word arriving now.
            discard  <= rsp_take ? outstanding - 1'b1 : outstanding;
         end else begin
            if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
            if (fifo_push) rsp_pc   <= rsp_pc + PC_STEP;
            if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (branch_taken),
      .wdata (wr_entry),
      .rdata (head),
      .empty (empty),
      .full  (full),
      .count (count)
   );

endmodule
